// File: rtl/sun_pll_lockdet_pkg.sv
// Shared types and helpers for the SUN PLL lock detector.
// Holds the FSM state encoding and the in-tolerance decision for a measured window.
package sun_pll_lockdet_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2,
      STALL = 2'd3
   } state_e;

   // Widened to int before subtracting so a short or long window can never wrap.
   function automatic logic in_tol(input int cnt, input int nom, input int tol);
      int diff;
      diff = cnt - nom;
      if (diff < 0) begin
         diff = -diff;
      end
      return (diff <= tol);
   endfunction

endpackage

// File: rtl/sun_pll_refsync.sv
// Brings the asynchronous reference clock into the CK domain.
// Emits a single-cycle REF_RISE on each synchronized rising edge.
module sun_pll_refsync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CK,
   input  logic RST,
   input  logic CK_REF,
   output logic REF_RISE
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   edge_q;

   always_ff @(posedge CK) begin
      if (RST) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], CK_REF};
         edge_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign REF_RISE = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/sun_pll_lockdet.sv
// Lock detector: counts CK cycles per reference period, reports each window,
// asserts LOCK after a run of in-tolerance windows and flags a stalled reference.
module sun_pll_lockdet
   import sun_pll_lockdet_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int NOM         = 32,
   parameter int TOL         = 2,
   parameter int LOCK_CNT    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             CK,
   input  logic             RST,
   input  logic             PWRUP_1V8,
   input  logic             CK_REF,
   output logic             LOCK,
   output logic [CNT_W-1:0] MEAS,
   output logic             MEAS_VLD,
   output logic             ERR
);

   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [3:0]       LOCK_CNT_L = 4'(LOCK_CNT);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] meas_q, meas_d;
   logic [3:0]       good_q, good_d;
   logic             lock_q, lock_d;
   logic             vld_q, vld_d;
   logic             err_q, err_d;
   logic             ref_rise;
   logic             win_good;
   logic [3:0]       good_inc;

   sun_pll_refsync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_refsync (
      .CK      (CK),
      .RST     (RST),
      .CK_REF  (CK_REF),
      .REF_RISE(ref_rise)
   );

   assign win_good = in_tol(int'(cnt_q), NOM, TOL);
   assign good_inc = (good_q == LOCK_CNT_L) ? good_q : good_q + 4'd1;

   // Power-down outranks everything; a reference edge on a saturated count still measures.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      meas_d  = meas_q;
      good_d  = good_q;
      lock_d  = lock_q;
      vld_d   = 1'b0;
      err_d   = err_q;
      if (!PWRUP_1V8) begin
         state_d = IDLE;
         cnt_d   = '0;
         good_d  = '0;
         lock_d  = 1'b0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = ARM;
            end
            ARM: begin
               if (ref_rise) begin
                  state_d = COUNT;
                  cnt_d   = CNT_ONE;
               end
            end
            COUNT: begin
               if (ref_rise) begin
                  meas_d = cnt_q;
                  vld_d  = 1'b1;
                  cnt_d  = CNT_ONE;
                  if (win_good) begin
                     good_d = good_inc;
                     lock_d = (good_inc == LOCK_CNT_L);
                  end else begin
                     good_d = '0;
                     lock_d = 1'b0;
                  end
               end else if (cnt_q == CNT_MAX) begin
                  state_d = STALL;
                  err_d   = 1'b1;
                  lock_d  = 1'b0;
                  good_d  = '0;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            STALL: begin
               if (ref_rise) begin
                  state_d = COUNT;
                  cnt_d   = CNT_ONE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge CK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         meas_q  <= '0;
         good_q  <= '0;
         lock_q  <= 1'b0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         meas_q  <= meas_d;
         good_q  <= good_d;
         lock_q  <= lock_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

   assign LOCK     = lock_q;
   assign MEAS     = meas_q;
   assign MEAS_VLD = vld_q;
   assign ERR      = err_q;

endmodule

// File: tb/tb_sun_pll_lockdet.sv
// Directed bench for sun_pll_lockdet: lock, tolerance edges, stall, power-down,
// reset and the saturation/edge collision, checked with immediate assertions.
module tb_sun_pll_lockdet;
   import sun_pll_lockdet_pkg::*;

   logic        CK = 1'b0;
   logic        RST;
   logic        PWRUP_1V8;
   logic        CK_REF;
   logic        LOCK;
   logic [7:0]  MEAS;
   logic        MEAS_VLD;
   logic        ERR;

   int          compared   = 0;
   int          mismatched = 0;
   int          cyc        = 0;
   int          callVld    = 0;
   int          vldCyc     = 0;
   int          errCyc     = -1;
   logic [31:0] lastMeas   = '0;
   logic [31:0] lastGood   = '0;
   logic        lastLock   = 1'b0;
   logic        lastErr    = 1'b0;
   logic        errLock    = 1'b0;
   logic        sawStall   = 1'b0;

   always #5 CK = ~CK;

   sun_pll_lockdet #(
      .CNT_W      (8),
      .NOM        (32),
      .TOL        (2),
      .LOCK_CNT   (4),
      .SYNC_STAGES(2)
   ) dut (
      .CK       (CK),
      .RST      (RST),
      .PWRUP_1V8(PWRUP_1V8),
      .CK_REF   (CK_REF),
      .LOCK     (LOCK),
      .MEAS     (MEAS),
      .MEAS_VLD (MEAS_VLD),
      .ERR      (ERR)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one cycle and record what the detector reported, sampled on the falling edge.
   task automatic sampleCycle();
      @(negedge CK);
      cyc++;
      if (MEAS_VLD === 1'b1) begin
         callVld++;
         lastMeas = 32'(MEAS);
         lastLock = LOCK;
         lastErr  = ERR;
         lastGood = 32'(dut.good_q);
         vldCyc   = cyc;
      end
      if (ERR === 1'b1 && errCyc < 0) begin
         errCyc  = cyc;
         errLock = LOCK;
      end
      if (dut.state_q == STALL) begin
         sawStall = 1'b1;
      end
   endtask

   // One reference period: rising edge at the start, high for 4 CK cycles.
   task automatic runPeriod(input int period);
      callVld = 0;
      for (int i = 0; i < period; i++) begin
         CK_REF = (i < 4);
         sampleCycle();
      end
   endtask

   task automatic checkWindow(input string tag, input int expMeas, input int expLock, input int expErr);
      check({tag, "_vld"}, 32'(callVld), 32'd1);
      check({tag, "_meas"}, lastMeas, 32'(expMeas));
      check({tag, "_lock"}, 32'(lastLock), 32'(expLock));
      check({tag, "_err"}, 32'(lastErr), 32'(expErr));
   endtask

   initial begin
      RST       = 1'b1;
      PWRUP_1V8 = 1'b0;
      CK_REF    = 1'b0;
      repeat (3) sampleCycle();
      check("rst_lock", 32'(LOCK), 32'd0);
      check("rst_meas", 32'(MEAS), 32'd0);
      check("rst_vld", 32'(MEAS_VLD), 32'd0);
      check("rst_err", 32'(ERR), 32'd0);
      check("rst_state", 32'(dut.state_q), 32'(IDLE));
      RST = 1'b0;

      // Nominal lock at 32 cycles per period
      PWRUP_1V8 = 1'b1;
      runPeriod(32);
      check("arm_novld", 32'(callVld), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         runPeriod(32);
         checkWindow($sformatf("nom%0d", k), 32, (k == 4) ? 1 : 0, 0);
      end

      // Tolerance edges: 30 and 34 good, 29 and 35 bad
      runPeriod(30);
      checkWindow("pre30", 32, 1, 0);
      runPeriod(34);
      checkWindow("tol30", 30, 1, 0);
      runPeriod(29);
      checkWindow("tol34", 34, 1, 0);
      runPeriod(32);
      checkWindow("tol29", 29, 0, 0);
      check("tol29_good", lastGood, 32'd0);
      for (int k = 1; k <= 3; k++) begin
         runPeriod(32);
         checkWindow($sformatf("relock%0d", k), 32, 0, 0);
      end
      runPeriod(35);
      checkWindow("relock4", 32, 1, 0);
      runPeriod(32);
      checkWindow("tol35", 35, 0, 0);
      check("tol35_good", lastGood, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         runPeriod(32);
         checkWindow($sformatf("lockB%0d", k), 32, (k == 4) ? 1 : 0, 0);
      end

      // Reference stall while locked
      errCyc = -1;
      repeat (300) begin
         CK_REF = 1'b0;
         sampleCycle();
      end
      check("stall_delay", 32'(errCyc - vldCyc), 32'd255);
      check("stall_lock_at_err", 32'(errLock), 32'd0);
      check("stall_err_hold", 32'(ERR), 32'd1);
      check("stall_state", 32'(dut.state_q), 32'(STALL));
      runPeriod(32);
      check("stall_first_edge_novld", 32'(callVld), 32'd0);
      runPeriod(32);
      checkWindow("stall_resume", 32, 0, 1);

      // Power-down part way into a window
      runPeriod(16);
      checkWindow("pd_pre", 32, 0, 1);
      PWRUP_1V8 = 1'b0;
      callVld   = 0;
      sampleCycle();
      check("pd_lock", 32'(LOCK), 32'd0);
      check("pd_err", 32'(ERR), 32'd0);
      check("pd_state", 32'(dut.state_q), 32'(IDLE));
      check("pd_meas", 32'(MEAS), 32'd32);
      check("pd_novld", 32'(callVld), 32'd0);

      // Power-down landing on the same cycle as a reference edge
      PWRUP_1V8 = 1'b1;
      runPeriod(32);
      runPeriod(32);
      checkWindow("pdr_win", 32, 0, 0);
      callVld = 0;
      CK_REF  = 1'b1;
      sampleCycle();
      sampleCycle();
      PWRUP_1V8 = 1'b0;
      sampleCycle();
      check("pdr_novld", 32'(callVld), 32'd0);
      check("pdr_state", 32'(dut.state_q), 32'(IDLE));
      CK_REF = 1'b0;
      repeat (4) sampleCycle();

      // Lock, then reset mid-window
      PWRUP_1V8 = 1'b1;
      runPeriod(32);
      for (int k = 1; k <= 4; k++) begin
         runPeriod(32);
      end
      check("prerst_lock", 32'(lastLock), 32'd1);
      repeat (6) sampleCycle();
      RST = 1'b1;
      sampleCycle();
      check("mrst_lock", 32'(LOCK), 32'd0);
      check("mrst_meas", 32'(MEAS), 32'd0);
      check("mrst_vld", 32'(MEAS_VLD), 32'd0);
      check("mrst_err", 32'(ERR), 32'd0);
      RST = 1'b0;
      runPeriod(32);
      check("rearm_novld", 32'(callVld), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         runPeriod(32);
         checkWindow($sformatf("rstlock%0d", k), 32, (k == 4) ? 1 : 0, 0);
      end

      // Reference edge exactly when the counter saturates
      sawStall = 1'b0;
      runPeriod(255);
      checkWindow("sat_pre", 32, 1, 0);
      runPeriod(32);
      checkWindow("sat", 255, 0, 0);
      check("sat_good", lastGood, 32'd0);
      check("sat_nostall", 32'(sawStall), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
